uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: grants one of two packet requesters the UART transmit FIFO, round-robin on ties,
// holding the grant for a whole packet and dropping it after IDLE_MAX idle cycles.
module uart_tx_arbiter #(
    parameter int DBIT     = 8,
    parameter int IDLE_MAX = 1023,
    parameter int IDLE_W   = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [DBIT-1:0] req0_data,
    input  logic            req0_last,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [DBIT-1:0] req1_data,
    input  logic            req1_last,
    output logic            req1_ready,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [1:0]      grant,
    output logic            abort
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

    logic [1:0]        state;
    logic              last_srv;
    logic [IDLE_W-1:0] idle_cnt;
    logic              own0, own1, sel_valid, sel_last, idle_tick;
    logic [DBIT-1:0]   sel_data;

    always_comb begin
        own0       = state == OWN0;
        own1       = state == OWN1;
        sel_valid  = own0 ? req0_valid : own1 ? req1_valid : 1'b0;
        sel_last   = own0 ? req0_last : req1_last;
        sel_data   = own0 ? req0_data : req1_data;
        req0_ready = own0 & ~tx_full;
        req1_ready = own1 & ~tx_full;
        wr_uart    = sel_valid & ~tx_full;
        w_data     = wr_uart ? sel_data : '0;
        idle_tick  = (own0 | own1) & ~sel_valid & ~tx_full;
        abort      = idle_tick & (idle_cnt == IDLE_W'(IDLE_MAX - 1));
    end

    assign grant = state;

    // last_srv resets to 1 so the first tie after reset goes to requester 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_srv <= 1'b1;
            idle_cnt <= '0;
        end else if (state == IDLE) begin
            idle_cnt <= '0;
            if (req0_valid & (last_srv | ~req1_valid)) state <= OWN0;
            else if (req1_valid) state <= OWN1;
        end else if (wr_uart) begin
            idle_cnt <= '0;
            if (sel_last) begin
                state    <= IDLE;
                last_srv <= own1;
            end
        end else if (abort) begin
            state    <= IDLE;
            last_srv <= own1;
            idle_cnt <= '0;
        end else if (idle_tick) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else if (~own0 & ~own1) begin
            state <= IDLE;
        end
    end
endmodule
